// File: rtl/debounce_pkg.sv
// debounce_pkg: shared defaults and helpers for the multi-channel debouncer
package debounce_pkg;

    localparam int DEFAULT_N_CH       = 4;
    localparam int DEFAULT_STABLE_CNT = 1000000;
    localparam int SIM_STABLE_CNT     = 4;

    function automatic int cnt_width(input int stable_cnt);
        return $clog2(stable_cnt + 1);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one channel (optional 2-flop sync, stability counter, clean level, strobes); DEBOUNCE_SYNC_EN enables the synchroniser
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int   STABLE_CNT = DEFAULT_STABLE_CNT,
    parameter logic INIT_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bouncey_in,
    output logic clean_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic change_nxt
);

    localparam int               CNT_W   = cnt_width(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

    logic             s;
    logic             accept;
    logic             clean_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;

`ifdef DEBOUNCE_SYNC_EN
    logic [1:0] sync_q;

    // two-flop synchroniser; the counter only ever sees the second stage
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync_q <= {2{INIT_VAL}};
        else        sync_q <= {sync_q[0], bouncey_in};

    assign s = sync_q[1];
`else
    assign s = bouncey_in;
`endif

    // count consecutive samples disagreeing with the clean level; accept on the last one
    always_comb begin
        accept  = (s != clean_out) && (cnt == CNT_MAX);
        cnt_d   = ((s == clean_out) || accept) ? '0 : cnt + 1'b1;
        clean_d = accept ? s : clean_out;
    end

    assign change_nxt = accept;

    // counter, clean level and strobes all update together so strobes line up with the new level
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt        <= '0;
            clean_out  <= INIT_VAL;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            cnt        <= cnt_d;
            clean_out  <= clean_d;
            rise_pulse <= accept & s;
            fall_pulse <= accept & ~s;
        end

endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: N-channel debouncer with per-channel strobes and a shared any_change flag; DEBOUNCE_SYNC_EN adds input synchronisers
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int   N_CH       = DEFAULT_N_CH,
    parameter int   STABLE_CNT = DEFAULT_STABLE_CNT,
    parameter logic INIT_VAL   = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] bouncey_in,
    output logic [N_CH-1:0] clean_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic            any_change
);

    logic [N_CH-1:0] chg_nxt;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_chan #(
            .STABLE_CNT (STABLE_CNT),
            .INIT_VAL   (INIT_VAL)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .bouncey_in (bouncey_in[i]),
            .clean_out  (clean_out[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i]),
            .change_nxt (chg_nxt[i])
        );
    end

    // registered from the channels' next-cycle acceptance so it coincides with the strobes
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) any_change <= 1'b0;
        else        any_change <= |chg_nxt;

endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: randomized and directed scoreboard bench for debounce_multi against a sample-history model
module tb_debounce_multi;

    localparam int N = 4;
    localparam int K = 4;
`ifdef DEBOUNCE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    typedef struct packed {
        logic [N-1:0] clean;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic         any;
        logic         c1;
        logic         r1;
        logic         f1;
        logic         a1;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] bouncey_in;
    logic [N-1:0] clean_out, rise_pulse, fall_pulse;
    logic         any_change;
    logic [0:0]   clean1, rise1, fall1;
    logic         any1;

    int errors = 0;
    int checks = 0;

    exp_t   sb[$];
    logic   [N-1:0] m_clean;
    logic   m1;
    logic   hist[N][$];
    logic   dly[N][$];
    logic   dly1[$];

    always #5 clk = ~clk;

    debounce_multi #(.N_CH(N), .STABLE_CNT(K), .INIT_VAL(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bouncey_in (bouncey_in),
        .clean_out  (clean_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .any_change (any_change)
    );

    debounce_multi #(.N_CH(1), .STABLE_CNT(1), .INIT_VAL(1'b0)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bouncey_in (bouncey_in[0:0]),
        .clean_out  (clean1),
        .rise_pulse (rise1),
        .fall_pulse (fall1),
        .any_change (any1)
    );

    task automatic model_reset();
        m_clean = '0;
        m1      = 1'b0;
        dly1.delete();
        for (int c = 0; c < N; c++) begin
            hist[c].delete();
            dly[c].delete();
            for (int j = 0; j < LAT; j++) dly[c].push_back(1'b0);
        end
        for (int j = 0; j < LAT; j++) dly1.push_back(1'b0);
    endtask

    // A new level is accepted once the most recent K samples all differ from the current level.
    task automatic model_step(input logic [N-1:0] v);
        exp_t         e;
        logic [N-1:0] prev;
        logic         p1, s, ok;
        prev = m_clean;
        p1   = m1;
        for (int c = 0; c < N; c++) begin
            s = v[c];
            if (LAT > 0) begin
                dly[c].push_back(v[c]);
                s = dly[c].pop_front();
            end
            hist[c].push_back(s);
            if (hist[c].size() > K) void'(hist[c].pop_front());
            ok = (hist[c].size() == K);
            for (int j = 0; j < hist[c].size(); j++)
                if (hist[c][j] == m_clean[c]) ok = 1'b0;
            if (ok) m_clean[c] = s;
        end
        s = v[0];
        if (LAT > 0) begin
            dly1.push_back(v[0]);
            s = dly1.pop_front();
        end
        m1      = s;
        e.clean = m_clean;
        e.rise  = m_clean & ~prev;
        e.fall  = ~m_clean & prev;
        e.any   = |(e.rise | e.fall);
        e.c1    = m1;
        e.r1    = m1 & ~p1;
        e.f1    = ~m1 & p1;
        e.a1    = m1 ^ p1;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [N-1:0] v, input int n);
        repeat (n) begin
            @(negedge clk);
            rst_n      = 1'b1;
            bouncey_in = v;
            model_step(v);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({clean_out, rise_pulse, fall_pulse, any_change, clean1, rise1, fall1, any1} !== '0) begin
            errors++;
            $display("FAIL async_reset: clean=%b rise=%b fall=%b any=%b c1=%b r1=%b f1=%b a1=%b, required all 0",
                     clean_out, rise_pulse, fall_pulse, any_change, clean1, rise1, fall1, any1);
        end
        model_reset();
        sb.push_back('0);
    endtask

    // monitor: every cycle the DUT presents outputs; compare against the oldest expectation
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = {clean_out, rise_pulse, fall_pulse, any_change, clean1[0], rise1[0], fall1[0], any1};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle_outputs @%0t: clean=%b rise=%b fall=%b any=%b | k1 c=%b r=%b f=%b a=%b ; required clean=%b rise=%b fall=%b any=%b | k1 c=%b r=%b f=%b a=%b",
                             $time, a.clean, a.rise, a.fall, a.any, a.c1, a.r1, a.f1, a.a1,
                             e.clean, e.rise, e.fall, e.any, e.c1, e.r1, e.f1, e.a1);
                end
                checks++;
                if ((rise_pulse & fall_pulse) !== '0) begin
                    errors++;
                    $display("FAIL strobe_exclusive @%0t: rise&fall=%b, required 0000", $time, rise_pulse & fall_pulse);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        logic [N-1:0] cur;
        rst_n      = 1'b0;
        bouncey_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({clean_out, rise_pulse, fall_pulse, any_change} !== '0) begin
            errors++;
            $display("FAIL reset_state: clean=%b rise=%b fall=%b any=%b, required 0000 0000 0000 0",
                     clean_out, rise_pulse, fall_pulse, any_change);
        end
        // short pulse on ch0 is a bounce
        drive(4'b0001, 3);
        drive(4'b0000, 6);
        // ch0 held high is accepted
        drive(4'b0001, 8);
        // ch1 accepted high, then bounces before a clean fall
        drive(4'b0011, 8);
        drive(4'b0001, 1);
        drive(4'b0011, 1);
        drive(4'b0001, 8);
        // all channels switch together
        drive(4'b0000, 8);
        drive(4'b1111, 8);
        drive(4'b0000, 8);
        // reset in the middle of a count on ch2
        drive(4'b0100, 3);
        pulse_reset();
        drive(4'b0100, 8);
        drive(4'b0000, 8);
        // toggle every 2 cycles: bounce for K=4, tracked by the K=1 instance
        repeat (8) begin
            drive(4'b0001, 2);
            drive(4'b0000, 2);
        end
        // random stimulus
        cur = '0;
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 3) == 0) cur[c] = ~cur[c];
            if ($urandom_range(0, 99) == 0) pulse_reset();
            drive(cur, 1);
        end
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
